// File: rtl/lamp_if.sv
// lamp_if: turn/hazard requests (master drives) and lamp/mode/busy/step status (slave drives)
interface lamp_if;
    logic       turn_left;
    logic       turn_right;
    logic       emergency;
    logic [2:0] left_lamp;
    logic [2:0] right_lamp;
    logic [1:0] mode;
    logic       busy;
    logic       step;
    modport master (
        output turn_left, turn_right, emergency,
        input  left_lamp, right_lamp, mode, busy, step
    );
    modport slave (
        input  turn_left, turn_right, emergency,
        output left_lamp, right_lamp, mode, busy, step
    );
endinterface

// File: rtl/lamp_sequencer.sv
// lamp_sequencer: turn/hazard lamp sequencer stepping every TICK_DIV cycles; ports clk, rst, bus (lamp_if.slave: requests in, lamps/mode/busy/step out)
module lamp_sequencer #(
    parameter int TICK_DIV = 4
) (
    input logic   clk,
    input logic   rst,
    lamp_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LEFT   = 2'd1;
    localparam logic [1:0] RIGHT  = 2'd2;
    localparam logic [1:0] HAZARD = 2'd3;
    logic [15:0] cnt;
    logic [1:0]  mode;
    logic [1:0]  phase;
    logic [1:0]  req;
    logic [2:0]  pat;
    logic [2:0]  haz;
    logic        tick;
    always_comb begin
        tick = cnt == 16'(TICK_DIV - 1);
        req  = (bus.emergency || (bus.turn_left && bus.turn_right)) ? HAZARD :
               bus.turn_left  ? LEFT  :
               bus.turn_right ? RIGHT : IDLE;
        pat  = {phase == 2'd3, phase[1], phase != 2'd0};
        haz  = {3{phase[0]}};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mode  <= IDLE;
            phase <= 2'd0;
        end else begin
            cnt <= tick ? '0 : cnt + 16'd1;
            if (tick) begin
                mode  <= req;
                phase <= (req == IDLE) ? 2'd0 : (req != mode) ? 2'd1 : phase + 2'd1;
            end
        end
    end
    assign bus.left_lamp  = (mode == LEFT)  ? pat : (mode == HAZARD) ? haz : 3'b000;
    assign bus.right_lamp = (mode == RIGHT) ? pat : (mode == HAZARD) ? haz : 3'b000;
    assign bus.mode       = mode;
    assign bus.busy       = mode != IDLE;
    assign bus.step       = tick;
endmodule
